// File: rtl/exp_job_feeder.sv
// Synchronous FIFO with a count register; depth must be a power of two, at least 2.
// Latency: a word pushed on an edge can be popped on the next edge.
// Backpressure: push_rdy drops while full, even if a pop happens in the same cycle.
module exp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Buffers host operands and issues one engine job at a time, capturing each result.
// Latency: push to eng_start 2 edges; engine ready to out_valid 1 edge.
// Backpressure: a full out register blocks new jobs, so the FIFO fills and in_ready drops.
module exp_job_feeder #(
    parameter int DW      = 8,
    parameter int RW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          eng_start,
    output logic [DW-1:0] eng_x,
    input  logic          eng_ready,
    input  logic          eng_busy,
    input  logic [RW-1:0] eng_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [7:0]    job_cnt,
    output logic          timeout_err
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          issue;
    logic          done;
    logic          expire;
    logic          fifo_vld;
    logic [DW-1:0] fifo_dat;
    logic [TW-1:0] timer;
    logic          unused_busy;

    assign unused_busy = eng_busy;

    exp_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (in_data),
        .pop_vld  (fifo_vld),
        .pop_rdy  (issue),
        .pop_dat  (fifo_dat)
    );

    // Completion is tested before the watchdog so a job finishing on the last allowed cycle still counts.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_vld && eng_ready && !out_valid) begin
                    issue     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (timer == TMAX) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end else if (!eng_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TMAX) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // timer holds the number of cycles elapsed since the start pulse cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            eng_start   <= 1'b0;
            eng_x       <= '0;
            timer       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            job_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            eng_start <= issue;
            if (issue) begin
                eng_x <= fifo_dat;
                timer <= '0;
            end else if (state != IDLE) begin
                timer <= timer + 1'b1;
            end
            if (done) begin
                out_valid <= 1'b1;
                out_data  <= eng_result;
                job_cnt   <= job_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exp_job_feeder.sv
// Directed bench for exp_job_feeder with a behavioural engine and a negedge monitor.
module tb_exp_job_feeder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        eng_start;
    logic [7:0]  eng_x;
    logic        eng_ready;
    logic        eng_busy;
    logic [15:0] eng_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  job_cnt;
    logic        timeout_err;

    int total;
    int bad;

    logic        eng_hold;
    logic        eng_hang;
    int          eng_lat;
    logic [15:0] res_base;

    logic [7:0]  issued_q[$];
    logic [15:0] res_q[$];
    bit          start_dbl;
    bit          x_bad;
    bit          od_bad;
    int          ib;
    int          rb;

    exp_job_feeder #(
        .DW      (8),
        .RW      (16),
        .DEPTH   (4),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_ready   (eng_ready),
        .eng_busy    (eng_busy),
        .eng_result  (eng_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .job_cnt     (job_cnt),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        @(negedge clk);
        for (int i = 0; i < 60 && !eng_start; i++) @(negedge clk);
        chk(tag, 32'(eng_start), 1);
    endtask

    task automatic wait_out(input string tag);
        @(negedge clk);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        chk(tag, 32'(out_valid), 1);
    endtask

    // Engine: leaves idle the cycle after it sees start, returns ready with res_base + x after eng_lat cycles.
    initial begin : engine_model
        bit         got_start;
        int         left;
        logic [7:0] cur_x;
        got_start  = 1'b0;
        left       = 0;
        cur_x      = '0;
        eng_ready  = 1'b1;
        eng_busy   = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_hold) begin
                eng_ready = 1'b0;
                eng_busy  = 1'b0;
                got_start = 1'b0;
            end else if (got_start) begin
                got_start = 1'b0;
                eng_ready = 1'b0;
                eng_busy  = 1'b1;
                left      = eng_lat;
                cur_x     = eng_x;
            end else if (eng_busy) begin
                if (!eng_hang) begin
                    if (left <= 1) begin
                        eng_busy   = 1'b0;
                        eng_ready  = 1'b1;
                        eng_result = res_base + {8'h00, cur_x};
                    end else begin
                        left--;
                    end
                end
            end else begin
                eng_ready = 1'b1;
            end
            if (eng_start) got_start = 1'b1;
        end
    end

    initial begin : monitor
        bit          prev_start;
        bit          prev_ov;
        logic [7:0]  prev_x;
        logic [15:0] prev_od;
        prev_start = 1'b0;
        prev_ov    = 1'b0;
        prev_x     = '0;
        prev_od    = '0;
        start_dbl  = 1'b0;
        x_bad      = 1'b0;
        od_bad     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (eng_start) begin
                    if (prev_start) start_dbl = 1'b1;
                    issued_q.push_back(eng_x);
                end
                if (!eng_start && eng_x != prev_x) x_bad = 1'b1;
                if (prev_ov && out_valid && out_data != prev_od) od_bad = 1'b1;
                if (out_valid && out_ready) res_q.push_back(out_data);
            end
            prev_start = eng_start;
            prev_x     = eng_x;
            prev_ov    = out_valid;
            prev_od    = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: no summary reached by time %0t", $time);
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        eng_hold  = 1'b0;
        eng_hang  = 1'b0;
        eng_lat   = 10;
        res_base  = 16'h011E;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_x", 32'(eng_x), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_job_cnt", 32'(job_cnt), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk); #1; rst = 1'b1;

        // Single job: x=0x05 -> 0x011E + 5 = 0x0123.
        out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h05;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("t1_start_early", 32'(eng_start), 0);
        @(negedge clk);
        chk("t1_start", 32'(eng_start), 1);
        chk("t1_eng_x", 32'(eng_x), 'h05);
        @(negedge clk);
        chk("t1_start_pulse", 32'(eng_start), 0);
        for (int i = 0; i < 60 && !eng_ready; i++) @(negedge clk);
        chk("t1_eng_ready_back", 32'(eng_ready), 1);
        chk("t1_out_valid_pre", 32'(out_valid), 0);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_data", 32'(out_data), 'h0123);
        chk("t1_job_cnt", 32'(job_cnt), 1);
        repeat (5) @(negedge clk);
        chk("t1_hold_valid", 32'(out_valid), 1);
        chk("t1_hold_data", 32'(out_data), 'h0123);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_out_clear", 32'(out_valid), 0);

        // FIFO fill with the engine stalled; results 0x1000 + x.
        res_base = 16'h1000;
        eng_lat  = 3;
        eng_hold = 1'b1;
        repeat (2) @(negedge clk);
        ib = issued_q.size();
        rb = res_q.size();
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h01;
        for (int i = 2; i <= 5; i++) begin
            @(posedge clk); #1; in_data = 8'(i);
        end
        @(negedge clk);
        chk("t2_full", 32'(in_ready), 0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("t2_still_full", 32'(in_ready), 0);
        chk("t2_no_issue_stalled", 32'(issued_q.size() - ib), 0);
        eng_hold = 1'b0;
        for (int i = 0; i < 300 && job_cnt != 8'd5; i++) @(negedge clk);
        chk("t2_job_cnt", 32'(job_cnt), 5);
        repeat (15) @(negedge clk);
        chk("t2_issued_count", 32'(issued_q.size() - ib), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_order%0d", i), 32'(issued_q[ib+i]), 32'(i + 1));
            chk($sformatf("t2_result%0d", i), 32'(res_q[rb+i]), 32'('h1001 + i));
        end

        // Backpressure: two queued jobs, consumer stalled.
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21;
        ib = issued_q.size();
        @(posedge clk); #1; in_data = 8'h22;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_out("t3_out1_seen");
        chk("t3_out1_data", 32'(out_data), 'h1021);
        repeat (20) @(negedge clk);
        chk("t3_held_valid", 32'(out_valid), 1);
        chk("t3_held_data", 32'(out_data), 'h1021);
        chk("t3_one_issue", 32'(issued_q.size() - ib), 1);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_cleared", 32'(out_valid), 0);
        chk("t3_no_start_yet", 32'(eng_start), 0);
        @(negedge clk);
        chk("t3_second_start", 32'(eng_start), 1);
        chk("t3_second_x", 32'(eng_x), 'h22);
        wait_out("t3_out2_seen");
        chk("t3_out2_data", 32'(out_data), 'h1022);
        chk("t3_job_cnt", 32'(job_cnt), 7);

        // Push 0x07 on the same edge that pops 0x06.
        @(negedge clk); eng_hold = 1'b1;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h06;
        ib = issued_q.size();
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_issue_stalled", 32'(issued_q.size() - ib), 0);
        eng_hold = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h07;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_start1", 32'(eng_start), 1);
        chk("t4_x1", 32'(eng_x), 'h06);
        chk("t4_in_ready", 32'(in_ready), 1);
        wait_out("t4_out1_seen");
        chk("t4_out1_data", 32'(out_data), 'h1006);
        wait_start("t4_start2");
        chk("t4_x2", 32'(eng_x), 'h07);
        wait_out("t4_out2_seen");
        chk("t4_out2_data", 32'(out_data), 'h1007);
        repeat (15) @(negedge clk);
        chk("t4_issue_count", 32'(issued_q.size() - ib), 2);
        chk("t4_job_cnt", 32'(job_cnt), 9);

        // Watchdog: engine never completes job 0x31; 0x32 still runs afterwards.
        @(negedge clk); eng_hang = 1'b1;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h31;
        rb = res_q.size();
        @(posedge clk); #1; in_data = 8'h32;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_start("t5_start1");
        chk("t5_x1", 32'(eng_x), 'h31);
        repeat (63) @(negedge clk);
        chk("t5_err_before", 32'(timeout_err), 0);
        @(negedge clk);
        chk("t5_err_at_64", 32'(timeout_err), 1);
        chk("t5_no_out_valid", 32'(out_valid), 0);
        chk("t5_job_cnt_kept", 32'(job_cnt), 9);
        eng_hang = 1'b0;
        wait_start("t5_start2");
        chk("t5_x2", 32'(eng_x), 'h32);
        wait_out("t5_out2_seen");
        chk("t5_out2_data", 32'(out_data), 'h1032);
        chk("t5_job_cnt", 32'(job_cnt), 10);
        chk("t5_err_sticky", 32'(timeout_err), 1);
        repeat (3) @(negedge clk);
        chk("t5_one_result", 32'(res_q.size() - rb), 1);

        // Asynchronous reset while waiting for the engine.
        eng_lat = 10;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h41;
        @(posedge clk); #1; in_data = 8'h42;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_start("t6_start");
        chk("t6_x", 32'(eng_x), 'h41);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_eng_start", 32'(eng_start), 0);
        chk("t6_rst_eng_x", 32'(eng_x), 0);
        chk("t6_rst_out_data", 32'(out_data), 0);
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_job_cnt", 32'(job_cnt), 0);
        chk("t6_rst_timeout_err", 32'(timeout_err), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b1;
        ib = issued_q.size();
        repeat (20) @(negedge clk);
        chk("t6_fifo_flushed", 32'(issued_q.size() - ib), 0);
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h09;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_start("t6_start_after");
        chk("t6_x_after", 32'(eng_x), 'h09);
        wait_out("t6_out_seen");
        chk("t6_out_data", 32'(out_data), 'h1009);
        chk("t6_job_cnt", 32'(job_cnt), 1);

        repeat (3) @(negedge clk);
        chk("start_never_double", 32'(start_dbl), 0);
        chk("eng_x_stable_in_job", 32'(x_bad), 0);
        chk("out_data_stable_while_valid", 32'(od_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exp_job_feeder.md
Name: exp_job_feeder

Overview:
Upstream feeder for the series-evaluation engine controller/datapath. It accepts operand x values from a host over a valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the engine over the engine's start/ready handshake, then captures each result into a valid/ready output register. A watchdog flags an engine that never completes a job.

Parameters:
DW, 8, operand x width
RW, 16, engine result width
DEPTH, 4, FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles allowed from start pulse to engine ready returning

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  host operand valid
in_ready  out  1  FIFO can accept (= !full)
in_data  in  DW  operand x
eng_start  out  1  start pulse to engine
eng_x  out  DW  operand to engine, held stable for the whole job
eng_ready  in  1  engine idle / result valid
eng_busy  in  1  engine computing (status only, not used for control)
eng_result  in  RW  engine result
out_valid  out  1  result register full
out_ready  in  1  consumer accepts result
out_data  out  RW  captured result
job_cnt  out  8  completed jobs, wraps 255->0
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): FSM=IDLE; FIFO empty; in_ready=1; eng_start=0; eng_x=0; out_valid=0; out_data=0; job_cnt=0; timeout_err=0; timer=0.
- FIFO push: in_valid && in_ready.
  - Full: in_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE -> ISSUE when FIFO non-empty && eng_ready && !out_valid. On that edge: pop head into eng_x register.
  - ISSUE: eng_start=1 for exactly one cycle; timer cleared; -> WAIT_ACK.
  - WAIT_ACK: eng_start=0. eng_ready==0 -> WAIT_DONE (the engine has left its idle state).
  - WAIT_DONE: eng_ready==1 -> capture eng_result into out_data; out_valid<=1; job_cnt++; -> IDLE.
- eng_start is registered and is never high for two consecutive cycles. The engine keeps reloading x while start is held, so one cycle is sufficient.
- eng_x changes only on the IDLE->ISSUE edge.
- Latency:
  - FIFO push to earliest eng_start: 2 cycles (push edge, then IDLE decision edge).
  - eng_ready rising in WAIT_DONE to out_valid: 1 cycle.
- Output handshake:
  - out_valid clears on out_valid && out_ready.
  - out_data stays stable while out_valid=1.
  - No new job is issued while out_valid=1. Backpressure therefore stalls the FIFO, not the engine.
- Watchdog:
  - The timer increments each cycle in WAIT_ACK and WAIT_DONE.
  - When timer reaches TIMEOUT-1 without the completing transition: timeout_err<=1 (sticky until reset), job dropped (no out_valid, job_cnt unchanged), -> IDLE.
  - If the completing transition and the timeout occur in the same cycle, completion wins.
- eng_ready already low in IDLE: the feeder waits and does not issue.
- Reset mid-job: all state cleared, FIFO contents discarded. eng_start is 0 during and after reset.

Test Plan:
- Single job: push x=0x05; engine model returns 0x0123 after 10 cycles -> eng_start one-cycle pulse 2 cycles after push, eng_x=0x05 throughout, out_valid with out_data=0x0123, job_cnt=1.
- FIFO fill: push 0x01..0x04 back-to-back with the engine stalled (eng_ready=0) -> in_ready=0 after 4th push. A 5th push with in_valid=1 is not accepted. Release the engine -> results issued in order 0x01,0x02,0x03,0x04.
- Backpressure: out_ready=0 with 2 queued jobs -> first result held stable, no second eng_start until out_ready=1. Then second job issued, 2 cycles after out_valid clears.
- Simultaneous push/pop: FIFO holding 1 entry, push 0x07 on the same edge as IDLE pops -> count stays 1, 0x07 issued next.
- Watchdog: TIMEOUT=64, engine drops ready and never returns -> timeout_err=1 at cycle 64 after start, no out_valid, job_cnt unchanged, next queued job still issued.
- Async reset mid-WAIT_DONE: assert rst=0 between clock edges -> all outputs at reset values immediately, FIFO empty; after release, push 0x09 -> normal completion.
